median_tracker_mc: RTL and testbench
====================================

MEDIAN_TRACKER_MC -- requirements
Module: median_tracker_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, signed detail-coefficient width.
REQ-002 SHALL have parameter MAX_WINDOW_SIZE, default 1024, the largest window in samples; a power of two.
REQ-003 SHALL have parameter NUM_CAND, default 8, candidate thresholds per pass; a power of two, at least 2; CAND_LOG = log2(NUM_CAND).
REQ-004 SHALL define the port clk  in  1  sole clock.
REQ-005 SHALL define the port rst  in  1  synchronous active-high reset.
REQ-006 SHALL define the port en_i  in  1  enable; low aborts the operation.
REQ-007 SHALL define the port start_i  in  1  one-cycle pulse that starts an estimate.
REQ-008 SHALL define the port continuous_i  in  1  when 1, restart automatically after each estimate.
REQ-009 SHALL define the port window_size_cfg  in  log2(MAX_WINDOW_SIZE)  window length N; 0 means MAX_WINDOW_SIZE.
REQ-010 SHALL define the port sample_i  in  DATA_WIDTH  signed two's-complement sample.
REQ-011 SHALL define the port sample_valid_i  in  1  sample qualifier.
REQ-012 SHALL define the port median_o  out  DATA_WIDTH  unsigned median of |sample|.
REQ-013 SHALL define the port median_valid_o  out  1  one-cycle pulse when median_o updates.
REQ-014 SHALL define the port lock_o  out  1  high once a median is valid; held until abort or reset.
REQ-015 SHALL define the port busy_o  out  1  high in any state other than IDLE.
REQ-016 SHALL define the port pass_o  out  log2(NUM_PASS)+1  index of the current pass.

Function
REQ-017 SHALL compute magnitude m = |sample_i| as DATA_WIDTH-bit unsigned; -2^(DATA_WIDTH-1) maps to exactly 2^(DATA_WIDTH-1), with no saturation.
REQ-018 SHALL define the median as the element of 0-based rank r = (N-1)>>1 in the ascending sort of m over the window.
REQ-019 SHALL resolve the median MSB-first in NUM_PASS = ceil(DATA_WIDTH/CAND_LOG) passes, each over a fresh window of N accepted samples, with a prefix register of NUM_PASS*CAND_LOG bits cleared at estimate start.
REQ-020 SHALL form candidate thresholds in pass p with shift s = (NUM_PASS-1-p)*CAND_LOG as t_k = prefix + ((k+1) << s), for k = 0..NUM_CAND-2.
REQ-021 SHALL keep NUM_CAND-1 counters c_k of width log2(MAX_WINDOW_SIZE)+1; each c_k increments when m < t_k.
REQ-022 SHALL compute digit d = number of k with c_k <= r at the end of each pass, then set prefix = prefix + (d << s).
REQ-023 SHALL implement the FSM IDLE -> COUNT -> DRAIN -> DECIDE -> (COUNT for the next pass | DONE) -> (COUNT if continuous_i | IDLE).
REQ-024 SHALL leave IDLE for COUNT on start_i with en_i high; N and r are latched at that point and held for all passes of the estimate.
REQ-025 SHALL accept a sample only when sample_valid_i is high, the state is COUNT, and fewer than N samples are accepted; COUNT goes to DRAIN on the cycle after the N-th accepted sample.
REQ-026 SHALL drop, uncounted, any samples presented in IDLE, DRAIN, DECIDE or DONE.
REQ-027 SHALL register magnitude in one pipeline stage before counting; DRAIN lets the final sample update the counters.
REQ-028 SHALL clear the counters and the accepted-sample count on entry to every pass.
REQ-029 SHALL, in DONE, load median_o with prefix truncated to DATA_WIDTH, pulse median_valid_o, and set lock_o.
REQ-030 SHALL assert median_valid_o exactly 3 cycles after the edge that accepted the last sample of the final pass.
REQ-031 SHALL hold median_o between updates.
REQ-032 SHALL, when en_i goes low in any state, go to IDLE next cycle and clear the counters, prefix and lock_o; median_o holds its value.
REQ-033 SHALL ignore start_i while busy_o is high.
REQ-034 SHALL ignore window_size_cfg changes mid-estimate until the next start.

Reset
REQ-035 SHALL apply the following on rst high at a clk edge: state = IDLE; counters, prefix, accepted count, pass_o, median_o = 0; median_valid_o, lock_o, busy_o = 0.
REQ-036 SHALL have rst take priority over en_i and start_i.

Structure
REQ-037 SHALL place the FSM state encoding and the NUM_PASS/CAND_LOG derivation in the shared package median_est_pkg.
REQ-038 SHALL place the counter bank and digit computation in the sub-module median_threshold_bank (inputs m, valid, prefix, shift, clear, r; output d).

Verification (DATA_WIDTH=14, NUM_CAND=8, NUM_PASS=5)
REQ-039 SHALL verify: N=8, start, 5x8 samples {-5,3,7,-1,2,9,-4,6} -> median_o=4, median_valid_o 3 cycles after the 40th accepted sample, lock_o=1.
REQ-040 SHALL verify: N=8, every sample -8192 -> median_o=8192.
REQ-041 SHALL verify: window_size_cfg=0, constant 100 -> 5120 samples accepted, median_o=100.
REQ-042 SHALL verify: continuous_i=1, N=4, values 10 then 20 -> two valid pulses with median_o 10 then 20, and no samples counted in DRAIN/DECIDE/DONE.
REQ-043 SHALL verify: en_i low during pass 2 -> IDLE next cycle, lock_o=0, median_o unchanged; a restart gives the correct median.
REQ-044 SHALL verify: rst asserted mid-COUNT -> all outputs 0 next cycle, and start_i is honoured afterwards.

Source files
------------

// File: rtl/median_est_pkg.sv
// Shared definitions for the multi-pass median tracker: FSM encoding and
// the pass/candidate geometry derived from the block parameters.
package median_est_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DRAIN,
    S_DECIDE,
    S_DONE
  } state_t;

  function automatic int cand_log(input int num_cand);
    return $clog2(num_cand);
  endfunction

  // Digits of CAND_LOG bits needed to cover DATA_WIDTH bits, rounded up.
  function automatic int num_pass(input int data_width, input int num_cand);
    int cl;
    cl = $clog2(num_cand);
    return (data_width + cl - 1) / cl;
  endfunction

endpackage

// File: rtl/median_threshold_bank.sv
// Counts how many window magnitudes fall below each candidate threshold of the
// current pass and reports how many thresholds lie at or below the median.
module median_threshold_bank
  import median_est_pkg::*;
#(
  parameter int DATA_WIDTH   = 14,
  parameter int NUM_CAND     = 8,
  parameter int PREFIX_WIDTH = 15,
  parameter int SHIFT_WIDTH  = 4,
  parameter int CNT_WIDTH    = 11,
  localparam int CAND_LOG    = cand_log(NUM_CAND)
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH-1:0]   m,
  input  logic                    valid,
  input  logic [PREFIX_WIDTH-1:0] prefix,
  input  logic [SHIFT_WIDTH-1:0]  shift,
  input  logic                    clear,
  input  logic [CNT_WIDTH-1:0]    r,
  output logic [CAND_LOG-1:0]     d
);

  // One spare bit so prefix + (NUM_CAND-1 << shift) never wraps.
  localparam int TW = PREFIX_WIDTH + 1;

  logic [CNT_WIDTH-1:0] cnt [NUM_CAND-1];
  logic [TW-1:0]        m_ext;

  assign m_ext = TW'(m);

  // NOTE: no rst here; the top folds rst into clear, so the counters
  // still come up at zero after a synchronous reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CAND - 1; k++) begin
      if (clear) begin
        cnt[k] <= '0;
      end else if (valid && (m_ext < (TW'(prefix) + (TW'(k + 1) << shift)))) begin
        cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  // A threshold with at most r magnitudes below it is not above the median.
  always_comb begin
    d = '0;
    for (int k = 0; k < NUM_CAND - 1; k++) begin
      if (cnt[k] <= r) d = d + 1'b1;
    end
  end

endmodule

// File: rtl/median_tracker_mc.sv
// Multi-pass median estimator of |sample| over an N-sample window; one digit
// of CAND_LOG bits is resolved per pass, MSB first.
module median_tracker_mc
  import median_est_pkg::*;
#(
  parameter int DATA_WIDTH      = 14,
  parameter int MAX_WINDOW_SIZE = 1024,
  parameter int NUM_CAND        = 8,
  localparam int CAND_LOG       = cand_log(NUM_CAND),
  localparam int NUM_PASS       = num_pass(DATA_WIDTH, NUM_CAND),
  localparam int WIN_W          = $clog2(MAX_WINDOW_SIZE),
  localparam int PASS_W         = $clog2(NUM_PASS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic [WIN_W-1:0]      window_size_cfg,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic [DATA_WIDTH-1:0] median_o,
  output logic                  median_valid_o,
  output logic                  lock_o,
  output logic                  busy_o,
  output logic [PASS_W-1:0]     pass_o
);

  localparam int PREFIX_W = NUM_PASS * CAND_LOG;
  localparam int SHIFT_W  = $clog2(PREFIX_W);
  localparam int CNT_W    = WIN_W + 1;

  state_t                state, state_next;
  logic [CNT_W-1:0]      acc_cnt, n_len, r_rank, n_cfg;
  logic [PREFIX_W-1:0]   prefix;
  logic [DATA_WIDTH-1:0] mag, m_reg;
  logic                  m_valid;
  logic                  accept, last_accept, last_pass;
  logic                  est_start, pass_start, bank_clear;
  logic [SHIFT_W-1:0]    shift;
  logic [CAND_LOG-1:0]   digit;

  // Two's-complement negate; the most negative code maps onto 2^(W-1).
  assign mag         = sample_i[DATA_WIDTH-1] ? (~sample_i + 1'b1) : sample_i;
  assign n_cfg       = (window_size_cfg == '0) ? CNT_W'(MAX_WINDOW_SIZE) : {1'b0, window_size_cfg};
  assign accept      = en_i && (state == S_COUNT) && sample_valid_i && (acc_cnt < n_len);
  assign last_accept = accept && (acc_cnt == n_len - 1'b1);
  assign last_pass   = (pass_o == PASS_W'(NUM_PASS - 1));
  assign shift       = SHIFT_W'((NUM_PASS - 1 - int'(pass_o)) * CAND_LOG);
  assign bank_clear  = rst || !en_i || est_start || pass_start;
  assign busy_o      = (state != S_IDLE);

  // NOTE: every output gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    est_start  = 1'b0;
    pass_start = 1'b0;
    if (!en_i) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_i) begin
                    state_next = S_COUNT;
                    est_start  = 1'b1;
                  end
        S_COUNT:  if (last_accept) state_next = S_DRAIN;
        S_DRAIN:  state_next = S_DECIDE;
        S_DECIDE: if (last_pass) begin
                    state_next = S_DONE;
                  end else begin
                    state_next = S_COUNT;
                    pass_start = 1'b1;
                  end
        S_DONE:   if (continuous_i) begin
                    state_next = S_COUNT;
                    est_start  = 1'b1;
                  end else begin
                    state_next = S_IDLE;
                  end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments, so every register here samples the
  // pre-edge values (DONE copies the old prefix while a restart clears it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      acc_cnt        <= '0;
      n_len          <= '0;
      r_rank         <= '0;
      prefix         <= '0;
      pass_o         <= '0;
      m_reg          <= '0;
      m_valid        <= 1'b0;
      median_o       <= '0;
      median_valid_o <= 1'b0;
      lock_o         <= 1'b0;
    end else begin
      state          <= state_next;
      median_valid_o <= 1'b0;
      m_valid        <= accept;
      if (accept) begin
        m_reg   <= mag;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (!en_i) begin
        acc_cnt <= '0;
        prefix  <= '0;
        pass_o  <= '0;
        lock_o  <= 1'b0;
        m_valid <= 1'b0;
      end else begin
        if (est_start) begin
          n_len   <= n_cfg;
          r_rank  <= (n_cfg - 1'b1) >> 1;
          prefix  <= '0;
          pass_o  <= '0;
          acc_cnt <= '0;
        end
        if (pass_start) begin
          pass_o  <= pass_o + 1'b1;
          acc_cnt <= '0;
        end
        if (state == S_DECIDE) prefix <= prefix + (PREFIX_W'(digit) << shift);
        if (state == S_DONE) begin
          median_o       <= prefix[DATA_WIDTH-1:0];
          median_valid_o <= 1'b1;
          lock_o         <= 1'b1;
        end
      end
    end
  end

  median_threshold_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CAND    (NUM_CAND),
    .PREFIX_WIDTH(PREFIX_W),
    .SHIFT_WIDTH (SHIFT_W),
    .CNT_WIDTH   (CNT_W)
  ) u_bank (
    .clk   (clk),
    .m     (m_reg),
    .valid (m_valid),
    .prefix(prefix),
    .shift (shift),
    .clear (bank_clear),
    .r     (r_rank),
    .d     (digit)
  );

endmodule

// File: tb/tb_median_tracker_mc.sv
// Directed bench for median_tracker_mc: table of whole estimates plus
// hand-written abort and reset sequences.
module tb_median_tracker_mc;

  localparam logic signed [13:0] JUNK = 14'sd8191;

  logic               clk = 1'b0;
  logic               rst;
  logic               en_i;
  logic               start_i;
  logic               continuous_i;
  logic [9:0]         window_size_cfg;
  logic signed [13:0] sample_i;
  logic               sample_valid_i;
  logic [13:0]        median_o;
  logic               median_valid_o;
  logic               lock_o;
  logic               busy_o;
  logic [3:0]         pass_o;

  int total = 0;
  int bad   = 0;

  median_tracker_mc dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_i),
    .start_i        (start_i),
    .continuous_i   (continuous_i),
    .window_size_cfg(window_size_cfg),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .median_o       (median_o),
    .median_valid_o (median_valid_o),
    .lock_o         (lock_o),
    .busy_o         (busy_o),
    .pass_o         (pass_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]       cfg;
    logic [3:0]       nvals;
    logic [7:0][13:0] vals;
    logic             cont;
    logic             from_idle;
    logic [13:0]      exp_med;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0][13:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][13:0] r;
    r[0] = 14'(a0); r[1] = 14'(a1); r[2] = 14'(a2); r[3] = 14'(a3);
    r[4] = 14'(a4); r[5] = 14'(a5); r[6] = 14'(a6); r[7] = 14'(a7);
    return r;
  endfunction

  function automatic vec_t mk(input int cfg, input int nvals, input logic [7:0][13:0] vals,
                              input bit cont, input bit from_idle, input int exp_med);
    vec_t v;
    v.cfg       = 10'(cfg);
    v.nvals     = 4'(nvals);
    v.vals      = vals;
    v.cont      = cont;
    v.from_idle = from_idle;
    v.exp_med   = 14'(exp_med);
    return v;
  endfunction

  // One full estimate: 5 passes of N samples, junk on every cycle the DUT must
  // drop, then the valid pulse checked on exactly the third edge after the
  // last accepted sample.
  task automatic run_est(input vec_t v, input string name);
    int n;
    n = (v.cfg == 0) ? 1024 : int'(v.cfg);
    @(negedge clk);
    window_size_cfg = v.cfg;
    continuous_i    = v.cont;
    if (v.from_idle) begin
      start_i        = 1'b1;
      sample_i       = JUNK;
      sample_valid_i = 1'b1;
      @(negedge clk);
      start_i         = 1'b0;
      window_size_cfg = v.cfg ^ 10'h3;
    end
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < n; i++) begin
        sample_i       = v.vals[i % int'(v.nvals)];
        sample_valid_i = 1'b1;
        @(negedge clk);
      end
      if (p < 4) begin
        for (int j = 0; j < 2; j++) begin
          sample_i = JUNK;
          @(negedge clk);
        end
      end
    end
    window_size_cfg = v.cfg;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s.valid_early%0d", name, j), 32'(median_valid_o), 32'd0);
      sample_i = JUNK;
      @(negedge clk);
    end
    sample_valid_i = 1'b0;
    check({name, ".valid"},  32'(median_valid_o), 32'd1);
    check({name, ".median"}, 32'(median_o),       32'(v.exp_med));
    check({name, ".lock"},   32'(lock_o),         32'd1);
    check({name, ".busy"},   32'(busy_o),         32'(v.cont));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(8, 8, pack8(-5, 3, 7, -1, 2, 9, -4, 6), 0, 1, 4);
    tbl[1] = mk(8, 1, pack8(-8192, 0, 0, 0, 0, 0, 0, 0), 0, 1, 8192);
    tbl[2] = mk(5, 5, pack8(100, -300, 200, -50, 7, 0, 0, 0), 0, 1, 100);
    tbl[3] = mk(3, 3, pack8(-8192, 8191, 0, 0, 0, 0, 0, 0), 0, 1, 8191);
    tbl[4] = mk(2, 2, pack8(3, -9, 0, 0, 0, 0, 0, 0), 0, 1, 3);
    tbl[5] = mk(0, 1, pack8(100, 0, 0, 0, 0, 0, 0, 0), 0, 1, 100);
    tbl[6] = mk(4, 1, pack8(10, 0, 0, 0, 0, 0, 0, 0), 1, 1, 10);
    tbl[7] = mk(4, 1, pack8(20, 0, 0, 0, 0, 0, 0, 0), 0, 0, 20);

    rst = 1'b1; en_i = 1'b1; start_i = 1'b0; continuous_i = 1'b0;
    window_size_cfg = 10'd8; sample_i = '0; sample_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.median", 32'(median_o),       32'd0);
    check("reset.valid",  32'(median_valid_o), 32'd0);
    check("reset.lock",   32'(lock_o),         32'd0);
    check("reset.busy",   32'(busy_o),         32'd0);
    check("reset.pass",   32'(pass_o),         32'd0);

    for (int t = 0; t < 8; t++) run_est(tbl[t], $sformatf("row%0d", t));

    // Abort during pass 2; median_o keeps the last result (20).
    @(negedge clk);
    window_size_cfg = 10'd8;
    start_i = 1'b1; sample_i = 14'sd50; sample_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (23) @(negedge clk);
    check("abort.pass_before", 32'(pass_o), 32'd2);
    check("abort.busy_before", 32'(busy_o), 32'd1);
    en_i = 1'b0;
    @(negedge clk);
    sample_valid_i = 1'b0;
    check("abort.busy",   32'(busy_o),   32'd0);
    check("abort.lock",   32'(lock_o),   32'd0);
    check("abort.median", 32'(median_o), 32'd20);
    check("abort.pass",   32'(pass_o),   32'd0);
    en_i = 1'b1;
    run_est(mk(8, 1, pack8(50, 0, 0, 0, 0, 0, 0, 0), 0, 1, 50), "restart");

    // Synchronous reset in the middle of COUNT.
    @(negedge clk);
    start_i = 1'b1; sample_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_i = 14'sd60; sample_valid_i = 1'b1;
      @(negedge clk);
    end
    check("midrst.busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; sample_valid_i = 1'b0;
    check("midrst.median", 32'(median_o),       32'd0);
    check("midrst.valid",  32'(median_valid_o), 32'd0);
    check("midrst.lock",   32'(lock_o),         32'd0);
    check("midrst.busy",   32'(busy_o),         32'd0);
    check("midrst.pass",   32'(pass_o),         32'd0);
    run_est(tbl[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
